// File: rtl/ysyx_22050019_lsu_pipe.sv
// ysyx_22050019_lsu_pipe -- execute-to-writeback memory stage.
//
// Takes one execute result per valid/ready handshake. Non-memory ops land in
// the registered writeback slot one cycle later. Loads and stores run a
// request/grant(/response) bus transaction with byte-lane alignment, write
// strobes and sign/zero extension of load data.
//
// Optional feature macro: LSU_MISALIGN_CHK_EN
//   defined   : misaligned load/store is not sent to the bus; it returns a
//               writeback with out_err=1, out_reg_we=0, out_wdata=address.
//   undefined : out_err stays 0; misaligned accesses go to the bus and any
//               strobe/data bits shifted past the bus width are dropped.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   in_valid/in_ready               upstream op handshake
//   in_result, in_store_data        ALU result / address, store source value
//   in_reg_we, in_rd                destination write enable and index
//   in_load, in_store, in_size,
//   in_unsigned                     memory op kind, size (0..3), zero-extend
//   bus_req/bus_gnt                 memory request handshake
//   bus_we, bus_addr, bus_wdata,
//   bus_wstrb                       aligned request fields
//   bus_rvalid, bus_rdata           read response (full aligned word)
//   out_valid/out_ready             writeback handshake
//   out_wdata, out_rd, out_reg_we,
//   out_err                         writeback payload and access-fault flag
//   busy                            a bus transaction is in flight
module ysyx_22050019_lsu_pipe #(
    parameter int XLEN   = 64,
    parameter int STRB   = XLEN / 8,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_result,
    input  logic [XLEN-1:0]   in_store_data,
    input  logic              in_reg_we,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_load,
    input  logic              in_store,
    input  logic [1:0]        in_size,
    input  logic              in_unsigned,
    output logic              bus_req,
    input  logic              bus_gnt,
    output logic              bus_we,
    output logic [XLEN-1:0]   bus_addr,
    output logic [XLEN-1:0]   bus_wdata,
    output logic [STRB-1:0]   bus_wstrb,
    input  logic              bus_rvalid,
    input  logic [XLEN-1:0]   bus_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_wdata,
    output logic [REG_AW-1:0] out_rd,
    output logic              out_reg_we,
    output logic              out_err,
    output logic              busy
);
    localparam int OFFW = $clog2(STRB);

    typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

    state_t              r_state;
    logic                r_bus_req;
    logic                r_bus_we;
    logic [XLEN-1:0]     r_bus_addr;
    logic [XLEN-1:0]     r_bus_wdata;
    logic [STRB-1:0]     r_bus_wstrb;
    logic [OFFW-1:0]     r_off;
    logic [1:0]          r_size;
    logic                r_unsigned;
    logic                r_reg_we;
    logic [REG_AW-1:0]   r_rd;
    logic                r_out_valid;
    logic [XLEN-1:0]     r_out_wdata;
    logic [REG_AW-1:0]   r_out_rd;
    logic                r_out_reg_we;
    logic                r_out_err;

    logic                w_acc;
    logic                w_mem;
    logic                w_mis;
    logic [1:0]          w_size;
    logic [OFFW-1:0]     w_off;
    logic [STRB-1:0]     w_mask;
    logic [STRB-1:0]     w_wstrb;
    logic [XLEN-1:0]     w_wdata;
    logic [XLEN-1:0]     w_addr;
    logic [XLEN-1:0]     w_sh;
    logic [XLEN-1:0]     w_top;
    logic [XLEN-1:0]     w_ld;
    logic [7:0]          w_nb;
    logic [7:0]          w_lsh;

    assign in_ready = (r_state == IDLE) && (!r_out_valid || out_ready);
    assign w_acc    = in_valid && in_ready;
    assign w_mem    = in_load || in_store;

    // A 32-bit datapath has no dword access; fold it onto word.
    assign w_size = (XLEN == 32 && in_size == 2'd3) ? 2'd2 : in_size;
    assign w_off  = in_result[OFFW-1:0];
    assign w_addr = {in_result[XLEN-1:OFFW], {OFFW{1'b0}}};

    always_comb begin
        w_mask = '0;
        case (w_size)
            2'd0:    w_mask = STRB'(8'h01);
            2'd1:    w_mask = STRB'(8'h03);
            2'd2:    w_mask = STRB'(8'h0F);
            default: w_mask = STRB'(8'hFF);
        endcase
    end

    // Same-width shifts drop whatever falls off the top lane.
    assign w_wstrb = w_mask << w_off;
    assign w_wdata = in_store_data << {w_off, 3'b000};

`ifdef LSU_MISALIGN_CHK_EN
    logic [2:0] w_amask;
    always_comb begin
        w_amask = 3'd0;
        case (w_size)
            2'd0:    w_amask = 3'd0;
            2'd1:    w_amask = 3'd1;
            2'd2:    w_amask = 3'd3;
            default: w_amask = 3'd7;
        endcase
    end
    assign w_mis = w_mem && |(in_result[2:0] & w_amask);
`else
    assign w_mis = 1'b0;
`endif

    // Load extraction: move the addressed bytes to bit 0, push them to the
    // top of the word, then shift back logically or arithmetically.
    assign w_sh  = bus_rdata >> {r_off, 3'b000};
    assign w_nb  = 8'd8 << r_size;
    assign w_lsh = 8'(XLEN) - w_nb;
    assign w_top = w_sh << w_lsh;
    assign w_ld  = r_unsigned ? (w_top >> w_lsh) : XLEN'($signed(w_top) >>> w_lsh);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_bus_req    <= 1'b0;
            r_bus_we     <= 1'b0;
            r_bus_addr   <= '0;
            r_bus_wdata  <= '0;
            r_bus_wstrb  <= '0;
            r_off        <= '0;
            r_size       <= 2'd0;
            r_unsigned   <= 1'b0;
            r_reg_we     <= 1'b0;
            r_rd         <= '0;
            r_out_valid  <= 1'b0;
            r_out_wdata  <= '0;
            r_out_rd     <= '0;
            r_out_reg_we <= 1'b0;
            r_out_err    <= 1'b0;
        end else begin
            if (r_out_valid && out_ready) r_out_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_acc) begin
                        if (w_mem && !w_mis) begin
                            r_state     <= REQ;
                            r_bus_req   <= 1'b1;
                            r_bus_we    <= in_store;
                            r_bus_addr  <= w_addr;
                            r_bus_wdata <= w_wdata;
                            r_bus_wstrb <= w_wstrb;
                            r_off       <= w_off;
                            r_size      <= w_size;
                            r_unsigned  <= in_unsigned;
                            r_reg_we    <= in_reg_we;
                            r_rd        <= in_rd;
                        end else begin
                            // Plain ALU result, or a faulting access that
                            // reports its address instead of data.
                            r_out_valid  <= 1'b1;
                            r_out_wdata  <= in_result;
                            r_out_rd     <= in_rd;
                            r_out_reg_we <= in_reg_we && !w_mis;
                            r_out_err    <= w_mis;
                        end
                    end
                end
                REQ: begin
                    if (bus_gnt) begin
                        r_bus_req <= 1'b0;
                        if (r_bus_we) begin
                            r_state      <= IDLE;
                            r_out_valid  <= 1'b1;
                            r_out_wdata  <= '0;
                            r_out_rd     <= r_rd;
                            r_out_reg_we <= 1'b0;
                            r_out_err    <= 1'b0;
                        end else begin
                            r_state <= RSP;
                        end
                    end
                end
                RSP: begin
                    if (bus_rvalid) begin
                        r_state      <= IDLE;
                        r_out_valid  <= 1'b1;
                        r_out_wdata  <= w_ld;
                        r_out_rd     <= r_rd;
                        r_out_reg_we <= r_reg_we;
                        r_out_err    <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus_req    = r_bus_req;
    assign bus_we     = r_bus_we;
    assign bus_addr   = r_bus_addr;
    assign bus_wdata  = r_bus_wdata;
    assign bus_wstrb  = r_bus_wstrb;
    assign out_valid  = r_out_valid;
    assign out_wdata  = r_out_wdata;
    assign out_rd     = r_out_rd;
    assign out_reg_we = r_out_reg_we;
    assign out_err    = r_out_err;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_ysyx_22050019_lsu_pipe.sv
// Scoreboard bench for ysyx_22050019_lsu_pipe (XLEN=64).
module tb_ysyx_22050019_lsu_pipe;
    localparam int XLEN = 64;
    localparam int STRB = 8;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid, in_ready;
    logic [XLEN-1:0] in_result, in_store_data;
    logic            in_reg_we;
    logic [AW-1:0]   in_rd;
    logic            in_load, in_store;
    logic [1:0]      in_size;
    logic            in_unsigned;
    logic            bus_req, bus_gnt, bus_we;
    logic [XLEN-1:0] bus_addr, bus_wdata;
    logic [STRB-1:0] bus_wstrb;
    logic            bus_rvalid;
    logic [XLEN-1:0] bus_rdata;
    logic            out_valid, out_ready;
    logic [XLEN-1:0] out_wdata;
    logic [AW-1:0]   out_rd;
    logic            out_reg_we, out_err, busy;

    ysyx_22050019_lsu_pipe #(.XLEN(XLEN), .REG_AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_store_data(in_store_data),
        .in_reg_we(in_reg_we), .in_rd(in_rd),
        .in_load(in_load), .in_store(in_store),
        .in_size(in_size), .in_unsigned(in_unsigned),
        .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_wdata(out_wdata), .out_rd(out_rd),
        .out_reg_we(out_reg_we), .out_err(out_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] d;
        logic [4:0]  rd;
        logic        we;
        logic        err;
    } wb_t;

    wb_t sb[$];
    int  n_cmp = 0;
    int  n_err = 0;
    int  n_busreq = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Writeback monitor: every accepted writeback must match the oldest
    // expected entry.
    always @(negedge clk) begin
        wb_t e;
        if (bus_req) n_busreq++;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("wb_unexpected", 64'(out_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                chk("wb_data", out_wdata, e.d);
                chk("wb_we", 64'(out_reg_we), 64'(e.we));
                chk("wb_err", 64'(out_err), 64'(e.err));
                if (e.we) chk("wb_rd", 64'(out_rd), 64'(e.rd));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic ld, input logic st, input logic [63:0] a,
                            input logic [63:0] sd, input logic [1:0] sz,
                            input logic uns, input logic we, input logic [4:0] rd);
        chk("in_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b1; in_load = ld; in_store = st; in_result = a;
        in_store_data = sd; in_size = sz; in_unsigned = uns;
        in_reg_we = we; in_rd = rd;
        step();
        in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0;
    endtask

    // Hold grant low for gdly cycles checking request stability, then grant;
    // loads then get one response beat.
    task automatic bus_txn(input logic [63:0] eaddr, input logic [7:0] estrb,
                           input logic [63:0] ewdata, input logic ewe,
                           input int gdly, input logic [63:0] rdata);
        for (int i = 0; i <= gdly; i++) begin
            chk("bus_req", 64'(bus_req), 64'd1);
            chk("bus_addr", bus_addr, eaddr);
            chk("bus_wstrb", 64'(bus_wstrb), 64'(estrb));
            chk("bus_wdata", bus_wdata, ewdata);
            chk("bus_we", 64'(bus_we), 64'(ewe));
            bus_gnt = (i == gdly);
            step();
        end
        bus_gnt = 1'b0;
        chk("bus_req_drop", 64'(bus_req), 64'd0);
        if (!ewe) begin
            bus_rvalid = 1'b1; bus_rdata = rdata;
            step();
            bus_rvalid = 1'b0; bus_rdata = '0;
        end
        chk("wb_latency", 64'(out_valid), 64'd1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_result = '0; in_store_data = '0;
        in_reg_we = 1'b0; in_rd = '0; in_load = 1'b0; in_store = 1'b0;
        in_size = 2'd0; in_unsigned = 1'b0; bus_gnt = 1'b0;
        bus_rvalid = 1'b0; bus_rdata = '0; out_ready = 1'b1;
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_bus_req", 64'(bus_req), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_wdata", out_wdata, 64'd0);
        chk("rst_wstrb", 64'(bus_wstrb), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk); rst_n = 1'b1;
        step();

        // ALU pass-through, latency 1, then three back-to-back.
        n_busreq = 0;
        sb.push_back('{64'h1234, 5'd5, 1'b1, 1'b0});
        drive_op(1'b0, 1'b0, 64'h1234, 64'd0, 2'd0, 1'b0, 1'b1, 5'd5);
        chk("alu_valid", 64'(out_valid), 64'd1);
        for (int k = 0; k < 3; k++) begin
            sb.push_back('{64'h100 + 64'(k), 5'(10 + k), 1'b1, 1'b0});
            chk("b2b_ready", 64'(in_ready), 64'd1);
            in_valid = 1'b1; in_result = 64'h100 + 64'(k); in_rd = 5'(10 + k); in_reg_we = 1'b1;
            step();
            chk("b2b_valid", 64'(out_valid), 64'd1);
        end
        in_valid = 1'b0;
        step();
        chk("alu_no_bus", 64'(n_busreq), 64'd0);

        // Byte loads, signed and unsigned.
        sb.push_back('{64'hFFFF_FFFF_FFFF_FF80, 5'd7, 1'b1, 1'b0});
        drive_op(1'b1, 1'b0, 64'h8000_0003, 64'd0, 2'd0, 1'b0, 1'b1, 5'd7);
        bus_txn(64'h8000_0000, 8'h08, 64'd0, 1'b0, 0, 64'h0000_0000_8000_0000);
        sb.push_back('{64'h80, 5'd8, 1'b1, 1'b0});
        drive_op(1'b1, 1'b0, 64'h8000_0003, 64'd0, 2'd0, 1'b1, 1'b1, 5'd8);
        bus_txn(64'h8000_0000, 8'h08, 64'd0, 1'b0, 1, 64'h0000_0000_8000_0000);

        // Store half, grant held off 3 cycles.
        sb.push_back('{64'd0, 5'd9, 1'b0, 1'b0});
        drive_op(1'b0, 1'b1, 64'h8000_0006, 64'hBEEF, 2'd1, 1'b0, 1'b1, 5'd9);
        bus_txn(64'h8000_0000, 8'hC0, 64'hBEEF_0000_0000_0000, 1'b1, 3, 64'd0);

        // Word signed, half unsigned, dword.
        sb.push_back('{64'hFFFF_FFFF_8765_4321, 5'd11, 1'b1, 1'b0});
        drive_op(1'b1, 1'b0, 64'h8000_0004, 64'd0, 2'd2, 1'b0, 1'b1, 5'd11);
        bus_txn(64'h8000_0000, 8'hF0, 64'd0, 1'b0, 0, 64'h8765_4321_0000_0000);
        sb.push_back('{64'hF00D, 5'd12, 1'b1, 1'b0});
        drive_op(1'b1, 1'b0, 64'h8000_0000, 64'd0, 2'd1, 1'b1, 1'b1, 5'd12);
        bus_txn(64'h8000_0000, 8'h03, 64'd0, 1'b0, 2, 64'h1111_2222_3333_F00D);
        sb.push_back('{64'hDEAD_BEEF_0123_4567, 5'd13, 1'b1, 1'b0});
        drive_op(1'b1, 1'b0, 64'h8000_0008, 64'd0, 2'd3, 1'b0, 1'b1, 5'd13);
        bus_txn(64'h8000_0008, 8'hFF, 64'd0, 1'b0, 0, 64'hDEAD_BEEF_0123_4567);

        // Misaligned word load at 0x80000002.
`ifdef LSU_MISALIGN_CHK_EN
        n_busreq = 0;
        sb.push_back('{64'h8000_0002, 5'd3, 1'b0, 1'b1});
        drive_op(1'b1, 1'b0, 64'h8000_0002, 64'd0, 2'd2, 1'b0, 1'b1, 5'd3);
        chk("mis_valid", 64'(out_valid), 64'd1);
        chk("mis_busy", 64'(busy), 64'd0);
        step();
        chk("mis_no_bus", 64'(n_busreq), 64'd0);
`else
        sb.push_back('{64'h3344_5566, 5'd3, 1'b1, 1'b0});
        drive_op(1'b1, 1'b0, 64'h8000_0002, 64'd0, 2'd2, 1'b0, 1'b1, 5'd3);
        bus_txn(64'h8000_0000, 8'h3C, 64'd0, 1'b0, 0, 64'h1122_3344_5566_7788);
`endif
        step();

        // Writeback backpressure with a second op waiting.
        out_ready = 1'b0;
        sb.push_back('{64'hA1, 5'd1, 1'b1, 1'b0});
        drive_op(1'b0, 1'b0, 64'hA1, 64'd0, 2'd0, 1'b0, 1'b1, 5'd1);
        chk("bp_valid", 64'(out_valid), 64'd1);
        chk("bp_not_ready", 64'(in_ready), 64'd0);
        sb.push_back('{64'hB2, 5'd2, 1'b1, 1'b0});
        in_valid = 1'b1; in_result = 64'hB2; in_rd = 5'd2; in_reg_we = 1'b1;
        step();
        step();
        chk("bp_still_blocked", 64'(in_ready), 64'd0);
        chk("bp_hold", out_wdata, 64'hA1);
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("bp_second", out_wdata, 64'hB2);
        chk("bp_second_valid", 64'(out_valid), 64'd1);
        step();
        chk("bp_drained", 64'(out_valid), 64'd0);

        // Reset while a request is pending.
        drive_op(1'b1, 1'b0, 64'h8000_0010, 64'd0, 2'd2, 1'b0, 1'b1, 5'd4);
        chk("req_pending", 64'(bus_req), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_req_bus_req", 64'(bus_req), 64'd0);
        chk("rst_req_busy", 64'(busy), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        step();

        // Reset while waiting for the response; a late response is dropped.
        drive_op(1'b1, 1'b0, 64'h8000_0010, 64'd0, 2'd2, 1'b0, 1'b1, 5'd4);
        bus_gnt = 1'b1;
        step();
        bus_gnt = 1'b0;
        chk("rsp_busy", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_rsp_busy", 64'(busy), 64'd0);
        chk("rst_rsp_bus_req", 64'(bus_req), 64'd0);
        chk("rst_rsp_valid", 64'(out_valid), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        step();
        chk("post_rst_ready", 64'(in_ready), 64'd1);
        bus_rvalid = 1'b1; bus_rdata = 64'h5555_5555_5555_5555;
        step();
        bus_rvalid = 1'b0;
        chk("late_rsp_dropped", 64'(out_valid), 64'd0);
        chk("late_rsp_busy", 64'(busy), 64'd0);

        step();
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ysyx_22050019_lsu_pipe.md
Name: ysyx_22050019_lsu_pipe

Overview:
Parametrised execute-to-writeback memory stage following the ALU in the single-issue core.
- Accepts one execute result per valid/ready handshake.
- Non-memory ops pass straight to a registered writeback slot.
- Loads and stores run a multi-cycle request/grant/response bus transaction, with byte-lane alignment, write strobes and sign/zero extension.
- Output is a valid/ready writeback port toward the register file.

Parameters:
- XLEN, 64, datapath and address width (32 or 64).
- STRB, XLEN/8, byte-strobe width (derived, do not override).
- REG_AW, 5, register-index width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream op valid
- in_ready  out  1  block can accept op
- in_result  in  XLEN  ALU result; effective address for load/store
- in_store_data  in  XLEN  store source register value
- in_reg_we  in  1  op writes rd
- in_rd  in  REG_AW  destination register
- in_load  in  1  op is load
- in_store  in  1  op is store (in_load and in_store never both 1)
- in_size  in  2  0=byte 1=half 2=word 3=dword
- in_unsigned  in  1  zero-extend load
- bus_req  out  1  memory request
- bus_gnt  in  1  request accepted this cycle
- bus_we  out  1  1=write
- bus_addr  out  XLEN  STRB-aligned address
- bus_wdata  out  XLEN  lane-shifted write data
- bus_wstrb  out  STRB  byte enables
- bus_rvalid  in  1  read data valid
- bus_rdata  in  XLEN  read data (full aligned word)
- out_valid  out  1  writeback valid
- out_ready  in  1  writeback consumed
- out_wdata  out  XLEN  writeback data
- out_rd  out  REG_AW  writeback register
- out_reg_we  out  1  writeback enable
- out_err  out  1  access fault flag
- busy  out  1  state != IDLE

Behaviour:
- Reset values (async, rst_n low): state IDLE, bus_req=0, bus_we=0, bus_addr/bus_wdata/bus_wstrb=0, out_valid=0, out_wdata=0, out_rd=0, out_reg_we=0, out_err=0.
- FSM states: IDLE, REQ, RSP.
- in_ready = (state==IDLE) && (!out_valid || out_ready). An op is accepted on in_valid && in_ready.
- Accept, non-memory op:
  - Next cycle out_valid=1, out_wdata=in_result, out_rd=in_rd, out_reg_we=in_reg_we. Latency 1.
  - Back-to-back ops sustain 1 per cycle while out_ready=1.
- Accept, load/store: capture all fields, go to REQ.
  - bus_req=1.
  - bus_addr = addr with low log2(STRB) bits cleared.
  - off = addr[log2(STRB)-1:0].
  - bus_wstrb = ((1<<(1<<size))-1) << off, truncated to STRB bits.
  - bus_wdata = store_data << (8*off), truncated.
  - bus_we = store.
  - All bus outputs stay stable until bus_gnt.
- REQ with bus_gnt:
  - Store: bus_req drops; next cycle out_valid=1, out_reg_we=0, out_wdata=0; state IDLE.
  - Load: bus_req drops; state RSP.
  - bus_rvalid is ignored in REQ.
- RSP with bus_rvalid:
  - sh = bus_rdata >> (8*off).
  - Take the low (8<<size) bits; sign-extend unless in_unsigned.
  - Next cycle out_valid=1, out_wdata=that value, out_reg_we=captured reg_we; state IDLE.
  - Minimum load latency: accept → out_valid 3 cycles.
- Output slot:
  - Holds until out_valid && out_ready.
  - The slot is always free when a load/store completes, because ops are accepted only with the slot free or draining.
- XLEN=32: size 3 is treated as size 2.
- Reset mid-transaction returns to IDLE immediately and drops bus_req. Any in-flight bus response is discarded; the bus side must be reset together with this block.

Optional Feature:
- LSU_MISALIGN_CHK_EN defined:
  - On accept of a load/store whose addr is not a multiple of (1<<size), no bus request is issued.
  - Next cycle out_valid=1, out_err=1, out_reg_we=0, out_wdata=addr. State stays IDLE.
- Not defined:
  - out_err is constant 0 and misaligned accesses go to the bus as computed.
  - Strobe/data bits shifted past STRB/XLEN are dropped.

Test Plan:
- ALU op in_result=0x1234, reg_we=1, rd=5, out_ready=1 → out_valid next cycle, out_wdata=0x1234, out_rd=5, bus_req never asserted.
- Load byte signed, XLEN=64, addr 0x80000003, bus_rdata=0x0000_0000_8000_0000 → out_wdata=0xFFFF_FFFF_FFFF_FF80; same with in_unsigned=1 → 0x80.
- Store half, addr 0x80000006, store_data=0xBEEF, bus_gnt held low 3 cycles → bus_addr=0x80000000, bus_wstrb=0xC0, bus_wdata[63:48]=0xBEEF, bus_we=1, all stable for 4 cycles; out_reg_we=0 after grant.
- out_ready=0 with two back-to-back ALU ops → first held in out slot, in_ready=0, second accepted the cycle out_ready rises; no data lost or duplicated.
- Load word at 0x80000002 → with LSU_MISALIGN_CHK_EN: out_err=1, out_wdata=0x80000002, no bus_req; without: bus_req=1, bus_wstrb=0x3C.
- rst_n pulsed low while in RSP → bus_req=0, out_valid=0, busy=0 asynchronously; in_ready=1 first cycle after release; a late bus_rvalid produces no writeback.
